// File: rtl/edge_tracer_if.sv
// Edge-tracer buses: dual-port label BRAM (read + write port) and the contour point stream.
// master = tracer side, slave = memory / downstream consumer side.
interface edge_tracer_if #(
   parameter int ADDR_W = 19
);
   logic [ADDR_W-1:0] mem_addr_rd;
   logic [2:0]        mem_rd_data;
   logic [ADDR_W-1:0] mem_addr_wr;
   logic [2:0]        mem_wr_data;
   logic              mem_we;
   logic              pt_valid;
   logic              pt_ready;
   logic [9:0]        pt_x;
   logic [8:0]        pt_y;

   modport master (
      output mem_addr_rd,
      input  mem_rd_data,
      output mem_addr_wr,
      output mem_wr_data,
      output mem_we,
      output pt_valid,
      input  pt_ready,
      output pt_x,
      output pt_y
   );

   modport slave (
      input  mem_addr_rd,
      output mem_rd_data,
      input  mem_addr_wr,
      input  mem_wr_data,
      input  mem_we,
      input  pt_valid,
      output pt_ready,
      input  pt_x,
      input  pt_y
   );
endinterface

// File: rtl/edge_tracer.sv
// Contour tracer: raster-scan for a seed edge pixel, follow its 8-connected contour, sweep marks to DONE_CODE.
// Latency: RD_LAT+1 cycles per scanned/swept pixel; points stall in EMIT until pt_ready.
// Backpressure: pt_valid held with stable pt_x/pt_y until accepted; EDGE_TRACER_BBOX_EN adds bounding-box outputs.
module edge_tracer #(
   parameter int         WIDTH       = 640,
   parameter int         HEIGHT      = 480,
   parameter int         MARGIN      = 36,
   parameter int         RD_LAT      = 2,
   parameter logic [2:0] EDGE_CODE   = 3'b011,
   parameter logic [2:0] TRACED_CODE = 3'b111,
   parameter logic [2:0] DONE_CODE   = 3'b001,
   parameter int         MAX_LEN     = 4095
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic [11:0]   o_num_pixels,
   output logic          o_closed,
   output logic          o_overflow,
`ifdef EDGE_TRACER_BBOX_EN
   output logic [9:0]    o_bbox_xmin,
   output logic [9:0]    o_bbox_xmax,
   output logic [8:0]    o_bbox_ymin,
   output logic [8:0]    o_bbox_ymax,
`endif
   edge_tracer_if.master bus
);
   localparam int ADDR_W = $clog2(WIDTH * HEIGHT);
   localparam int WAIT_W = $clog2(RD_LAT + 1);

   localparam logic [WAIT_W-1:0] LAT_C     = WAIT_W'(RD_LAT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_W       = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] A_WP1     = ADDR_W'(WIDTH + 1);
   localparam logic [ADDR_W-1:0] A_WM1     = ADDR_W'(WIDTH - 1);
   localparam logic [9:0]        XMAX      = 10'(WIDTH - 1);
   localparam logic [8:0]        YMAX      = 9'(HEIGHT - 1);
   localparam logic [9:0]        MARG_X    = 10'(MARGIN);
   localparam logic [8:0]        MARG_Y    = 9'(MARGIN);
   localparam logic [11:0]       MAXLEN_C  = 12'(MAX_LEN);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_SCAN    = 4'd1;
   localparam logic [3:0] S_SCAN_W  = 4'd2;
   localparam logic [3:0] S_EXPLORE = 4'd3;
   localparam logic [3:0] S_EXP_W   = 4'd4;
   localparam logic [3:0] S_CHECK   = 4'd5;
   localparam logic [3:0] S_EMIT    = 4'd6;
   localparam logic [3:0] S_SWEEP   = 4'd7;
   localparam logic [3:0] S_SWEEP_W = 4'd8;
   localparam logic [3:0] S_FIN     = 4'd9;

   logic [3:0]        r_state;
   logic              r_busy, r_done, r_closed, r_overflow, r_mem_we, r_prev_vld;
   logic [11:0]       r_num;
   logic [ADDR_W-1:0] r_rd_addr, r_wr_addr, r_scan_addr, r_seed_addr;
   logic [ADDR_W-1:0] r_cur_addr, r_prev_addr, r_nbr_addr;
   logic [2:0]        r_wr_data, r_rd_q, r_dir;
   logic [9:0]        r_scan_x, r_cur_x, r_nbr_x;
   logic [8:0]        r_scan_y, r_cur_y, r_nbr_y;
   logic [WAIT_W-1:0] r_wait;

   logic [9:0]        w_nbr_x;
   logic [8:0]        w_nbr_y;
   logic [ADDR_W-1:0] w_nbr_addr;
   logic              w_off_img, w_skip, w_scan_hit, w_rd_ok, w_last, w_pt_valid, w_pt_acc;
   logic [11:0]       w_num_inc;

   // Neighbour of cur for the current direction; off-image directions are skipped so addresses never wrap rows.
   always_comb begin
      w_nbr_x    = r_cur_x;
      w_nbr_y    = r_cur_y;
      w_nbr_addr = r_cur_addr;
      w_off_img  = 1'b0;
      case (r_dir)
         3'd0: begin
            w_nbr_x = r_cur_x + 10'd1; w_nbr_addr = r_cur_addr + A_ONE;
            w_off_img = (r_cur_x == XMAX);
         end
         3'd1: begin
            w_nbr_x = r_cur_x + 10'd1; w_nbr_y = r_cur_y + 9'd1; w_nbr_addr = r_cur_addr + A_WP1;
            w_off_img = (r_cur_x == XMAX) || (r_cur_y == YMAX);
         end
         3'd2: begin
            w_nbr_y = r_cur_y + 9'd1; w_nbr_addr = r_cur_addr + A_W;
            w_off_img = (r_cur_y == YMAX);
         end
         3'd3: begin
            w_nbr_x = r_cur_x - 10'd1; w_nbr_y = r_cur_y + 9'd1; w_nbr_addr = r_cur_addr + A_WM1;
            w_off_img = (r_cur_x == 10'd0) || (r_cur_y == YMAX);
         end
         3'd4: begin
            w_nbr_x = r_cur_x - 10'd1; w_nbr_addr = r_cur_addr - A_ONE;
            w_off_img = (r_cur_x == 10'd0);
         end
         3'd5: begin
            w_nbr_x = r_cur_x - 10'd1; w_nbr_y = r_cur_y - 9'd1; w_nbr_addr = r_cur_addr - A_WP1;
            w_off_img = (r_cur_x == 10'd0) || (r_cur_y == 9'd0);
         end
         3'd6: begin
            w_nbr_y = r_cur_y - 9'd1; w_nbr_addr = r_cur_addr - A_W;
            w_off_img = (r_cur_y == 9'd0);
         end
         3'd7: begin
            w_nbr_x = r_cur_x + 10'd1; w_nbr_y = r_cur_y - 9'd1; w_nbr_addr = r_cur_addr - A_WM1;
            w_off_img = (r_cur_x == XMAX) || (r_cur_y == 9'd0);
         end
      endcase
   end

   assign w_skip     = w_off_img || (r_prev_vld && (w_nbr_addr == r_prev_addr));
   assign w_scan_hit = (bus.mem_rd_data == EDGE_CODE) && (r_scan_x >= MARG_X) && (r_scan_y >= MARG_Y);
   assign w_rd_ok    = (r_wait == LAT_C);
   assign w_last     = (r_scan_addr == LAST_ADDR);
   assign w_pt_valid = (r_state == S_EMIT);
   assign w_pt_acc   = w_pt_valid && bus.pt_ready;
   assign w_num_inc  = r_num + 12'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_closed    <= 1'b0;
         r_overflow  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_prev_vld  <= 1'b0;
         r_num       <= '0;
         r_rd_addr   <= '0;
         r_wr_addr   <= '0;
         r_scan_addr <= '0;
         r_seed_addr <= '0;
         r_cur_addr  <= '0;
         r_prev_addr <= '0;
         r_nbr_addr  <= '0;
         r_wr_data   <= '0;
         r_rd_q      <= '0;
         r_dir       <= '0;
         r_scan_x    <= '0;
         r_scan_y    <= '0;
         r_cur_x     <= '0;
         r_cur_y     <= '0;
         r_nbr_x     <= '0;
         r_nbr_y     <= '0;
         r_wait      <= '0;
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_busy      <= 1'b1;
                  r_num       <= '0;
                  r_closed    <= 1'b0;
                  r_overflow  <= 1'b0;
                  r_scan_addr <= '0;
                  r_scan_x    <= '0;
                  r_scan_y    <= '0;
                  r_state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_rd_addr <= r_scan_addr;
               r_wait    <= '0;
               r_state   <= S_SCAN_W;
            end
            S_SCAN_W: begin
               if (!w_rd_ok) begin
                  r_wait <= r_wait + 1'b1;
               end else if (w_scan_hit) begin
                  r_seed_addr <= r_scan_addr;
                  r_cur_addr  <= r_scan_addr;
                  r_cur_x     <= r_scan_x;
                  r_cur_y     <= r_scan_y;
                  r_prev_vld  <= 1'b0;
                  r_mem_we    <= 1'b1;
                  r_wr_addr   <= r_scan_addr;
                  r_wr_data   <= TRACED_CODE;
                  r_state     <= S_EMIT;
               end else if (w_last) begin
                  r_state <= S_FIN;
               end else begin
                  // Issue the next read straight away so each pixel costs RD_LAT+1 cycles.
                  r_scan_addr <= r_scan_addr + A_ONE;
                  r_rd_addr   <= r_scan_addr + A_ONE;
                  r_wait      <= '0;
                  if (r_scan_x == XMAX) begin
                     r_scan_x <= '0;
                     r_scan_y <= r_scan_y + 9'd1;
                  end else begin
                     r_scan_x <= r_scan_x + 10'd1;
                  end
               end
            end
            S_EXPLORE: begin
               if (w_skip) begin
                  if (r_dir == 3'd7) begin
                     r_closed    <= 1'b0;
                     r_scan_addr <= '0;
                     r_state     <= S_SWEEP;
                  end else begin
                     r_dir <= r_dir + 3'd1;
                  end
               end else begin
                  r_nbr_addr <= w_nbr_addr;
                  r_nbr_x    <= w_nbr_x;
                  r_nbr_y    <= w_nbr_y;
                  r_rd_addr  <= w_nbr_addr;
                  r_wait     <= '0;
                  r_state    <= S_EXP_W;
               end
            end
            S_EXP_W: begin
               if (!w_rd_ok) begin
                  r_wait <= r_wait + 1'b1;
               end else begin
                  r_rd_q  <= bus.mem_rd_data;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if ((r_nbr_addr == r_seed_addr) && (r_num >= 12'd3)) begin
                  r_closed    <= 1'b1;
                  r_scan_addr <= '0;
                  r_state     <= S_SWEEP;
               end else if (r_rd_q == EDGE_CODE) begin
                  r_prev_vld  <= 1'b1;
                  r_prev_addr <= r_cur_addr;
                  r_cur_addr  <= r_nbr_addr;
                  r_cur_x     <= r_nbr_x;
                  r_cur_y     <= r_nbr_y;
                  r_mem_we    <= 1'b1;
                  r_wr_addr   <= r_nbr_addr;
                  r_wr_data   <= TRACED_CODE;
                  r_state     <= S_EMIT;
               end else if (r_dir == 3'd7) begin
                  r_closed    <= 1'b0;
                  r_scan_addr <= '0;
                  r_state     <= S_SWEEP;
               end else begin
                  r_dir   <= r_dir + 3'd1;
                  r_state <= S_EXPLORE;
               end
            end
            S_EMIT: begin
               if (w_pt_acc) begin
                  r_num <= w_num_inc;
                  if (w_num_inc == MAXLEN_C) begin
                     r_overflow  <= 1'b1;
                     r_scan_addr <= '0;
                     r_state     <= S_SWEEP;
                  end else begin
                     r_dir   <= '0;
                     r_state <= S_EXPLORE;
                  end
               end
            end
            S_SWEEP: begin
               r_rd_addr <= r_scan_addr;
               r_wait    <= '0;
               r_state   <= S_SWEEP_W;
            end
            S_SWEEP_W: begin
               if (!w_rd_ok) begin
                  r_wait <= r_wait + 1'b1;
               end else begin
                  if (bus.mem_rd_data == TRACED_CODE) begin
                     r_mem_we  <= 1'b1;
                     r_wr_addr <= r_scan_addr;
                     r_wr_data <= DONE_CODE;
                  end
                  if (w_last) begin
                     r_state <= S_FIN;
                  end else begin
                     r_scan_addr <= r_scan_addr + A_ONE;
                     r_rd_addr   <= r_scan_addr + A_ONE;
                     r_wait      <= '0;
                  end
               end
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef EDGE_TRACER_BBOX_EN
   logic [9:0] r_bx_min, r_bx_max;
   logic [8:0] r_by_min, r_by_max;

   always_ff @(posedge i_clk) begin
      if (i_rst || ((r_state == S_IDLE) && i_start)) begin
         r_bx_min <= '0;
         r_bx_max <= '0;
         r_by_min <= '0;
         r_by_max <= '0;
      end else if ((r_state == S_SCAN_W) && w_rd_ok && w_scan_hit) begin
         r_bx_min <= r_scan_x;
         r_bx_max <= r_scan_x;
         r_by_min <= r_scan_y;
         r_by_max <= r_scan_y;
      end else if (w_pt_acc) begin
         if (r_cur_x < r_bx_min) r_bx_min <= r_cur_x;
         if (r_cur_x > r_bx_max) r_bx_max <= r_cur_x;
         if (r_cur_y < r_by_min) r_by_min <= r_cur_y;
         if (r_cur_y > r_by_max) r_by_max <= r_cur_y;
      end
   end

   assign o_bbox_xmin = r_bx_min;
   assign o_bbox_xmax = r_bx_max;
   assign o_bbox_ymin = r_by_min;
   assign o_bbox_ymax = r_by_max;
`endif

   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_num_pixels    = r_num;
   assign o_closed        = r_closed;
   assign o_overflow      = r_overflow;
   assign bus.mem_addr_rd = r_rd_addr;
   assign bus.mem_addr_wr = r_wr_addr;
   assign bus.mem_wr_data = r_wr_data;
   assign bus.mem_we      = r_mem_we;
   assign bus.pt_valid    = w_pt_valid;
   assign bus.pt_x        = r_cur_x;
   assign bus.pt_y        = r_cur_y;
endmodule

// File: tb/tb_edge_tracer.sv
// Directed bench for edge_tracer on a reduced 60x48 frame with a behavioural label BRAM.
module tb_edge_tracer;
   localparam int         W    = 60;
   localparam int         H    = 48;
   localparam int         MG   = 36;
   localparam int         RL   = 1;
   localparam int         AW   = $clog2(W * H);
   localparam logic [2:0] EDGE = 3'b011;
   localparam logic [2:0] TRC  = 3'b111;
   localparam logic [2:0] DN   = 3'b001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, closed, overflow;
   logic [11:0] num;

   edge_tracer_if #(.ADDR_W(AW)) bus();

`ifdef EDGE_TRACER_BBOX_EN
   logic [9:0] bxmin, bxmax;
   logic [8:0] bymin, bymax;
`endif

   edge_tracer #(
      .WIDTH(W), .HEIGHT(H), .MARGIN(MG), .RD_LAT(RL),
      .EDGE_CODE(EDGE), .TRACED_CODE(TRC), .DONE_CODE(DN), .MAX_LEN(4095)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_busy(busy), .o_done(done), .o_num_pixels(num),
      .o_closed(closed), .o_overflow(overflow),
`ifdef EDGE_TRACER_BBOX_EN
      .o_bbox_xmin(bxmin), .o_bbox_xmax(bxmax), .o_bbox_ymin(bymin), .o_bbox_ymax(bymax),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Label BRAM model: bench load port has priority, then the DUT write port.
   logic [2:0]    mem [W*H];
   logic [2:0]    rd_pipe [RL];
   logic          tb_clr = 1'b0, tb_set = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [2:0]    tb_dat = '0;

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < W*H; i++) mem[i] <= 3'b000;
      end else if (tb_set) begin
         mem[tb_addr] <= tb_dat;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr_wr] <= bus.mem_wr_data;
      end
      rd_pipe[0] <= mem[bus.mem_addr_rd];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rd_data = rd_pipe[RL-1];

   logic [9:0] px[$];
   logic [8:0] py[$];
   int         n_done_wr = 0;

   always @(negedge clk) begin
      if (bus.pt_valid && bus.pt_ready) begin
         px.push_back(bus.pt_x);
         py.push_back(bus.pt_y);
      end
      if (bus.mem_we && bus.mem_wr_data == DN) n_done_wr++;
   end

   int         n_chk = 0;
   int         n_fail = 0;
   logic [9:0] ex[$];
   logic [8:0] ey[$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mem();
      tb_clr = 1'b1;
      step();
      tb_clr = 1'b0;
   endtask

   task automatic set_px(int x, int y, logic [2:0] v);
      tb_addr = AW'(y * W + x);
      tb_dat  = v;
      tb_set  = 1'b1;
      step();
      tb_set  = 1'b0;
   endtask

   task automatic gen_ring(int x0, int y0);
      ex.delete();
      ey.delete();
      for (int x = x0; x <= x0 + 7; x++) begin ex.push_back(10'(x)); ey.push_back(9'(y0)); end
      for (int y = y0 + 1; y <= y0 + 7; y++) begin ex.push_back(10'(x0 + 7)); ey.push_back(9'(y)); end
      for (int x = x0 + 6; x >= x0; x--) begin ex.push_back(10'(x)); ey.push_back(9'(y0 + 7)); end
      for (int y = y0 + 6; y >= y0 + 1; y--) begin ex.push_back(10'(x0)); ey.push_back(9'(y)); end
   endtask

   task automatic load_exp();
      for (int i = 0; i < ex.size(); i++) set_px(int'(ex[i]), int'(ey[i]), EDGE);
   endtask

   task automatic start_run(string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic wait_done(string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 30000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"}, done, 1);
   endtask

   task automatic after_done(string tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_low"}, busy, 0);
      step();
   endtask

   task automatic chk_seq(string tag, int base);
      chk({tag, "_npts"}, px.size() - base, ex.size());
      for (int i = 0; i < ex.size() && base + i < px.size(); i++)
         chk($sformatf("%s_pt%0d", tag, i), {px[base+i], py[base+i]}, {ex[i], ey[i]});
   endtask

   task automatic chk_idle(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_num"}, num, 0);
      chk({tag, "_closed"}, closed, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_we"}, bus.mem_we, 0);
      chk({tag, "_pt_valid"}, bus.pt_valid, 0);
      chk({tag, "_addr_rd"}, bus.mem_addr_rd, 0);
      chk({tag, "_addr_wr"}, bus.mem_addr_wr, 0);
      chk({tag, "_pt_x"}, bus.pt_x, 0);
   endtask

   task automatic ring_results(string tag, int base, int dbase);
      chk({tag, "_num"}, num, 28);
      chk({tag, "_closed"}, closed, 1);
      chk({tag, "_ovf"}, overflow, 0);
      chk_seq(tag, base);
      chk({tag, "_done_wr"}, n_done_wr - dbase, 28);
   endtask

   initial begin
      int base, dbase, k;
      bus.pt_ready = 1'b1;

      // Reset state
      repeat (3) step();
      @(negedge clk);
      chk_idle("rst");
      step();
      rst = 1'b0;
      step();

      // 8x8 ring touching the bottom image row
      clr_mem();
      gen_ring(40, 40);
      load_exp();
      base = px.size(); dbase = n_done_wr;
      start_run("ring");
      wait_done("ring");
      ring_results("ring", base, dbase);
      after_done("ring");
      chk("ring_mem_corner", mem[40*W+40], DN);
      chk("ring_mem_inner", mem[44*W+44], 0);

      // Blank frame
      clr_mem();
      base = px.size(); dbase = n_done_wr;
      start_run("blank");
      wait_done("blank");
      chk("blank_num", num, 0);
      chk("blank_closed", closed, 0);
      chk("blank_npts", px.size() - base, 0);
      chk("blank_done_wr", n_done_wr - dbase, 0);
      after_done("blank");

      // Open line reaching the right image border
      clr_mem();
      ex.delete(); ey.delete();
      for (int x = 50; x <= 59; x++) begin ex.push_back(10'(x)); ey.push_back(9'd44); end
      load_exp();
      base = px.size();
      start_run("line");
      wait_done("line");
      chk("line_num", num, 10);
      chk("line_closed", closed, 0);
      chk_seq("line", base);
      after_done("line");
      chk("line_mem", mem[44*W+55], DN);

      // Edge pixel outside the margin is never a seed
      clr_mem();
      set_px(10, 10, EDGE);
      gen_ring(44, 38);
      load_exp();
      base = px.size(); dbase = n_done_wr;
      start_run("margin");
      wait_done("margin");
      ring_results("margin", base, dbase);
      after_done("margin");
      chk("margin_mem_10_10", mem[10*W+10], EDGE);

      // Backpressure on the third point; start while busy is ignored
      clr_mem();
      gen_ring(40, 40);
      load_exp();
      base = px.size(); dbase = n_done_wr;
      start_run("stall");
      k = 0;
      while (px.size() < base + 2 && k < 30000) begin step(); k++; end
      bus.pt_ready = 1'b0;
      k = 0;
      while (bus.pt_valid !== 1'b1 && k < 30000) begin step(); k++; end
      for (int i = 0; i < 5; i++) begin
         if (i == 0) start = 1'b1;
         @(negedge clk);
         chk($sformatf("stall_hold%0d", i), {bus.pt_valid, bus.pt_x, bus.pt_y}, {1'b1, 10'd42, 9'd40});
         step();
         start = 1'b0;
      end
      bus.pt_ready = 1'b1;
      wait_done("stall");
      ring_results("stall", base, dbase);
      after_done("stall");

      // Reset while exploring from the seed, then retrace a reloaded frame
      clr_mem();
      load_exp();
      base = px.size();
      start_run("mrst");
      k = 0;
      while (px.size() < base + 1 && k < 30000) begin step(); k++; end
      rst = 1'b1;
      step();
      chk_idle("mrst");
      chk("mrst_label_kept", mem[40*W+40], TRC);
      rst = 1'b0;
      step();
      clr_mem();
      load_exp();
      base = px.size(); dbase = n_done_wr;
      start_run("retrace");
      wait_done("retrace");
      ring_results("retrace", base, dbase);
      after_done("retrace");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
